// File: rtl/sram_rd_arbiter_pkg.sv
// Shared constants, grant classification and the round-robin pointer helper
// for the SRAM read-port arbiter.
package sram_rd_arbiter_pkg;

  // Upper bound on the number of requesters the arbiter is built for.
  localparam int NREQ_MAX = 8;

  // Port identities: port 0 is the real-time VGA fetch, the rest are
  // decompressor stages sharing the round-robin set.
  localparam int PORT_VGA  = 0;
  localparam int PORT_DEC0 = 1;
  localparam int PORT_DEC1 = 2;
  localparam int PORT_DEC2 = 3;
  localparam int PORT_DEC3 = 4;
  localparam int PORT_DEC4 = 5;
  localparam int PORT_DEC5 = 6;
  localparam int PORT_DEC6 = 7;

  // Why a port won this cycle; drives rr_ptr and starve updates.
  typedef enum logic [1:0] {
    GNT_NONE     = 2'd0,
    GNT_OVERRIDE = 2'd1,
    GNT_VGA      = 2'd2,
    GNT_RR       = 2'd3
  } gnt_kind_e;

  // Round-robin pointer after a grant to port k: k+1, wrapping back to the
  // first decompressor port once past the last port.
  function automatic int rr_after(input int k, input int nreq);
    return (k + 1 > nreq - 1) ? PORT_DEC0 : k + 1;
  endfunction

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Tracks in-flight reads through the SRAM read latency: an RD_LAT-deep
// shift register of {valid, port index} with a one-hot decode at the tail.
module sram_rd_tag_pipe #(
  parameter int NREQ   = 3,
  parameter int RD_LAT = 1,
  parameter int PIW    = 2
) (
  input  logic            clk,
  input  logic            reset_n_i,
  input  logic            valid_i,
  input  logic [PIW-1:0]  idx_i,
  output logic [NREQ-1:0] onehot_o
);

  logic           valid_q [RD_LAT];
  logic [PIW-1:0] idx_q   [RD_LAT];

  // Load the new grant at the head every cycle and shift older tags toward the tail.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        valid_q[i] <= 1'b0;
        idx_q[i]   <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= idx_i;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  // The tag leaving the pipe names the port that owns this cycle's read data.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
    assign onehot_o[gi] = valid_q[RD_LAT-1] && (idx_q[RD_LAT-1] == PIW'(gi));
  end

endmodule

// File: rtl/sram_rd_arbiter.sv
// Shares the single SRAM read port between NREQ requesters. Port 0 (VGA) has
// strict priority, the remaining ports are served round-robin, and a port
// that has waited MAX_WAIT cycles overrides everyone. Read data is steered
// back with a per-port rvalid exactly RD_LAT cycles after the grant.
module sram_rd_arbiter
  import sram_rd_arbiter_pkg::*;
#(
  parameter int AW       = 18,
  parameter int DW       = 16,
  parameter int NREQ     = 3,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic [AW-1:0]    sram_raddr,
  input  logic [DW-1:0]    sram_rdata,
  output logic             starve
);

  localparam int         PIW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [AW-1:0]   addr_arr [NREQ];
  logic [NREQ-1:0] ovr_vec;
  logic [PIW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            starve_q, starve_d;
  gnt_kind_e       gnt_kind;
  logic [PIW-1:0]  gnt_idx;
  logic            issue;
  logic [NREQ-1:0] pipe_onehot;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
    assign addr_arr[gi] = addr[gi*AW +: AW];
  end

  assign ovr_vec[PORT_VGA] = 1'b0;

  // Per-port wait counters for the round-robin set; a counter at MAX_WAIT
  // flags that port as starving.
  for (genvar gi = PORT_DEC0; gi < NREQ; gi++) begin : g_wait
    logic [7:0] cnt_q, cnt_d;

    // Count cycles spent requesting without a grant, saturating at MAX_WAIT.
    always_comb begin
      cnt_d = cnt_q;
      if (!req[gi] || gnt[gi]) begin
        cnt_d = '0;
      end else if (cnt_q != MAX_WAIT_C) begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign ovr_vec[gi] = req[gi] && (cnt_q == MAX_WAIT_C);
  end

  // Pick this cycle's winner: starving port first, then VGA, then round-robin scan.
  always_comb begin : arb_comb
    int             rr_cand;
    logic [PIW-1:0] rr_cand_idx;
    logic           rr_hit;
    logic [PIW-1:0] rr_idx;
    logic           ovr_hit;
    logic [PIW-1:0] ovr_idx;

    rr_cand     = 0;
    rr_cand_idx = '0;
    rr_hit      = 1'b0;
    rr_idx      = '0;
    ovr_hit     = 1'b0;
    ovr_idx     = '0;
    gnt_kind    = GNT_NONE;
    gnt_idx     = '0;

    // Scan downward so the lowest-index starving port is the last write.
    for (int i = NREQ - 1; i >= PORT_DEC0; i--) begin
      if (ovr_vec[i]) begin
        ovr_hit = 1'b1;
        ovr_idx = PIW'(i);
      end
    end

    // Upward scan from rr_ptr over ports 1..NREQ-1 with wrap back to 1.
    for (int off = 0; off < NREQ - 1; off++) begin
      rr_cand = int'(rr_ptr_q) + off;
      if (rr_cand > NREQ - 1) begin
        rr_cand = rr_cand - (NREQ - 1);
      end
      rr_cand_idx = PIW'(rr_cand);
      if (!rr_hit && req[rr_cand_idx]) begin
        rr_hit = 1'b1;
        rr_idx = rr_cand_idx;
      end
    end

    if (ovr_hit) begin
      gnt_kind = GNT_OVERRIDE;
      gnt_idx  = ovr_idx;
    end else if (req[PORT_VGA]) begin
      gnt_kind = GNT_VGA;
      gnt_idx  = PIW'(PORT_VGA);
    end else if (rr_hit) begin
      gnt_kind = GNT_RR;
      gnt_idx  = rr_idx;
    end
  end

  // Nothing is issued while reset is held, even if requests are present.
  assign issue = reset && (gnt_kind != GNT_NONE);

  // Drive the one-hot grant and the SRAM address; both idle to zero.
  always_comb begin
    gnt        = '0;
    sram_raddr = '0;
    if (issue) begin
      gnt[gnt_idx] = 1'b1;
      sram_raddr   = addr_arr[gnt_idx];
    end
  end

  // Next round-robin pointer and starvation flag.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    starve_d = 1'b0;
    if (issue && (gnt_kind == GNT_VGA || gnt_kind == GNT_RR)) begin
      rr_ptr_d = PIW'(rr_after(int'(gnt_idx), NREQ));
    end
    if (issue && gnt_kind == GNT_OVERRIDE) begin
      starve_d = 1'b1;
    end
  end

  // Round-robin pointer and starvation flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= PIW'(PORT_DEC0);
      starve_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
    end
  end

  sram_rd_tag_pipe #(
    .NREQ   (NREQ),
    .RD_LAT (RD_LAT),
    .PIW    (PIW)
  ) u_tag_pipe (
    .clk       (clk),
    .reset_n_i (reset),
    .valid_i   (issue),
    .idx_i     (gnt_idx),
    .onehot_o  (pipe_onehot)
  );

  // Tags already in the pipe are discarded by reset, so rvalid is also masked
  // during the reset cycle itself.
  assign rvalid = reset ? pipe_onehot : '0;
  assign rdata  = sram_rdata;
  assign starve = starve_q;

endmodule
